uart_tx_mmio: RTL
=================

Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter peripheral and bus responder. It sits beside the data memory on the core's memory bus (mem_addr/mem_wdata/mem_rdata/mem_r_enable/mem_w_enable). Core stores push bytes into a small TX FIFO. An 8N1 serializer drains the FIFO onto txd. Core loads return status.

Parameters:
BASE_ADDR, 32'h1000_0000, peripheral base; decode compares mem_addr[31:4] against BASE_ADDR[31:4]
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 2
FIFO_DEPTH, 4, TX FIFO entries; power of two, minimum 2

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous, active-low reset
mem_addr  input  32  byte address from the core
mem_wdata  input  32  store data; only [7:0] used for TXDATA
mem_w_enable  input  1  store strobe, one cycle per access
mem_r_enable  input  1  load strobe, one cycle per access
mem_rdata  output  32  load response; zero when not selected, so top can OR-merge it with memory
txd  output  1  UART serial out, idle high
leds  output  5  LED register, present only with MMIO_LED_EN

Behaviour:
- Single clock, clk. Reset is synchronous and active-low (reset_n sampled on the rising edge of clk).
- Reset values: txd=1, mem_rdata=0, FIFO empty, overflow=0, FSM=IDLE, leds=0.
- Select: sel = (mem_addr[31:4] == BASE_ADDR[31:4]). Offset = mem_addr[3:2]. mem_addr[1:0] ignored.
- Register map:
  - 0x0 TXDATA: W pushes mem_wdata[7:0]; R returns 0.
  - 0x4 STATUS: R = {26'b0, count[2:0], overflow, busy, full}, where bit0=full, bit1=busy (FSM != IDLE or FIFO not empty), bit2=overflow, bits[5:3]=count. Writes are ignored.
  - 0x8 LEDS: see optional feature. Otherwise reads 0 and writes are ignored.
- Read latency: exactly 1 cycle. mem_rdata is registered from the mem_r_enable & sel cycle. It returns to 0 on the next cycle unless another selected read occurs.
- Push: on mem_w_enable & sel & offset 0 & !full.
- Push while full: byte dropped, overflow set (sticky). A STATUS read returns overflow=1 and clears it on the same edge. If a set and a clear coincide, the set wins.
- Simultaneous push and pop while full: the pop frees a slot first, so the push is accepted and no overflow is flagged.
- FIFO: circular buffer, read/write pointers wrap modulo FIFO_DEPTH. count is clog2(FIFO_DEPTH)+1 bits wide and reports 0..FIFO_DEPTH.
- Serializer FSM (baud counter counts 0..CLKS_PER_BIT-1; bit index counts 0..7):
  - IDLE: txd=1. If FIFO not empty, pop into the shift register and go to START on the next cycle.
  - START: txd=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: txd=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. Shift right after each bit; after bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame length is 10*CLKS_PER_BIT cycles. Back-to-back frames add one IDLE cycle between STOP and the next START.
- Reset mid-frame: txd returns to 1 on the next edge. The FIFO is flushed and the partial frame is abandoned.
- Accesses that are not selected leave all state unchanged.
- mem_r_enable and mem_w_enable both high at a selected address: the write and read are both performed. The read returns pre-write status.

Optional Feature:
MMIO_LED_EN:
- Defined: the leds port exists and offset 0x8 is a R/W register. A write latches mem_wdata[4:0]; a read returns {27'b0, leds}. Reset value is 0.
- Undefined: no leds port; offset 0x8 reads 0 and writes are ignored.

Decomposition:
- Package uart_mmio_pkg holds:
  - register offset constants OFF_TXDATA, OFF_STATUS, OFF_LEDS
  - the STATUS bit index constants
  - typedef enum logic [1:0] tx_state_t {IDLE, START, DATA, STOP}
- One sub-module, uart_tx_serializer, is natural. Its ports are clk, reset_n, valid, data[7:0], ready (high in IDLE), busy and txd; it contains the FSM plus the baud and bit counters.
- The FIFO and bus decode stay in the top module.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=32'h1000_0000):
- Reset: hold reset_n=0 for 3 cycles → txd=1, mem_rdata=0; a read at 0x1000_0004 returns 0.
- Single byte: store 0xA5 to 0x1000_0000 → txd starts low one cycle later, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high. Frame length is 40 cycles. STATUS busy=1 during the frame and 0 after.
- Overflow: 6 stores (0x01..0x06) on consecutive cycles → the first pops immediately and 4 fill the FIFO, so 0x06 is dropped. STATUS reads full=1, overflow=1; a second read shows overflow=0. Exactly 5 frames appear, carrying 0x01..0x05.
- Simultaneous push and pop: FIFO full at the moment the FSM pops while a store arrives → byte accepted, overflow stays 0.
- Decode/latency: load from 0x2000_0004 → mem_rdata stays 0. Load from 0x1000_0004 → value valid exactly 1 cycle later, 0 the cycle after.
- Reset mid-frame: assert reset_n=0 at cycle 15 of a frame → txd=1 on the next edge, count=0, no further frames.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions, serializer states and a
// STATUS word packing helper.
package uart_mmio_pkg;

    // Word offsets, taken from mem_addr[3:2]
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_LEDS   = 2'd2;

    // STATUS register bit positions
    localparam int STAT_FULL    = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 3;
    localparam int STAT_CNT_MSB = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Pack the STATUS word: {26'b0, count[2:0], overflow, busy, full}
    function automatic logic [31:0] build_status(input logic       full,
                                                 input logic       busy,
                                                 input logic       ovf,
                                                 input logic [2:0] cnt);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[STAT_FULL]                  = full;
        w[STAT_BUSY]                  = busy;
        w[STAT_OVF]                   = ovf;
        w[STAT_CNT_MSB:STAT_CNT_LSB]  = cnt;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: start bit, eight data bits LSB first, one stop bit.
// Each bit lasts CLKS_PER_BIT clocks. txd is a registered output.
module uart_tx_serializer
    import uart_mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       busy,
    output logic       txd
);

    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;

    assign ready = (state_q == IDLE);
    assign busy  = (state_q != IDLE);
    assign txd   = txd_q;

    // Next-state logic: FSM, baud counter, bit counter, shifter and line level
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = 1'b1;

        case (state_q)
            IDLE: begin
                baud_d = {BW{1'b0}};
                bit_d  = 3'd0;
                if (valid) begin
                    shift_d = data;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = {BW{1'b0}};
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = {BW{1'b0}};
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = {BW{1'b0}};
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = {BW{1'b0}};
                bit_d   = 3'd0;
            end
        endcase

        // Line level follows the state being entered so txd is registered
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // State register with synchronous active-low reset; line idles high
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= {BW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: bus decode, TX FIFO, sticky overflow
// flag and registered read data (zero when not selected, for OR-merging).
// Optional LED register at offset 0x8 is enabled by defining MMIO_LED_EN.
module uart_tx_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_w_enable,
    input  logic        mem_r_enable,
    output logic [31:0] mem_rdata,
    output logic        txd
`ifdef MMIO_LED_EN
    ,
    output logic [4:0]  leds
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          sel_s, rd_s, wr_s;
    logic [1:0]    off_s;
    logic          empty_s, full_s, busy_s;
    logic          push_req_s, push_s, pop_s;
    logic          ovf_set_s, ovf_clr_s;
    logic          ser_ready_s, ser_busy_s;
    logic [2:0]    cnt3_s;
    logic          unused_s;

`ifdef MMIO_LED_EN
    logic [4:0]    leds_q, leds_d;
    assign leds = leds_q;
`endif

    assign sel_s   = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign off_s   = mem_addr[3:2];
    assign rd_s    = mem_r_enable & sel_s;
    assign wr_s    = mem_w_enable & sel_s;

    assign empty_s = (count_q == {CW{1'b0}});
    assign full_s  = (count_q == CW'(FIFO_DEPTH));
    assign busy_s  = ser_busy_s | ~empty_s;
    assign cnt3_s  = 3'(count_q);

    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept
    assign pop_s      = ser_ready_s & ~empty_s;
    assign push_req_s = wr_s & (off_s == OFF_TXDATA);
    assign push_s     = push_req_s & (~full_s | pop_s);
    assign ovf_set_s  = push_req_s & full_s & ~pop_s;
    assign ovf_clr_s  = rd_s & (off_s == OFF_STATUS);

    assign mem_rdata  = rdata_q;
    assign unused_s   = ^{mem_wdata[31:8], mem_addr[1:0]};

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   (~empty_s),
        .data    (fifo_q[rd_ptr_q]),
        .ready   (ser_ready_s),
        .busy    (ser_busy_s),
        .txd     (txd)
    );

    // Next-state for FIFO pointers/count, overflow flag, read data and LEDs
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        rdata_d  = 32'h0000_0000;
`ifdef MMIO_LED_EN
        leds_d   = leds_q;
`endif

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Set wins over a coincident STATUS-read clear
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        // Reads sample the pre-write state
        if (rd_s) begin
            case (off_s)
                OFF_STATUS: rdata_d = build_status(full_s, busy_s, ovf_q, cnt3_s);
`ifdef MMIO_LED_EN
                OFF_LEDS:   rdata_d = {27'h000_0000, leds_q};
`endif
                default:    rdata_d = 32'h0000_0000;
            endcase
        end else begin
            rdata_d = 32'h0000_0000;
        end

`ifdef MMIO_LED_EN
        if (wr_s && (off_s == OFF_LEDS)) begin
            leds_d = mem_wdata[4:0];
        end else begin
            leds_d = leds_q;
        end
`endif
    end

    // Control registers with synchronous active-low reset (flushes the FIFO)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            ovf_q    <= 1'b0;
            rdata_q  <= 32'h0000_0000;
`ifdef MMIO_LED_EN
            leds_q   <= 5'd0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
`ifdef MMIO_LED_EN
            leds_q   <= leds_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (reset_n && push_s) begin
            fifo_q[wr_ptr_q] <= mem_wdata[7:0];
        end
    end

endmodule
